// File: rtl/rfsoc_config.sv
// Shared configuration constants for the RFSoC converter control blocks:
// GPIO serial-bus bit indices, config register width and the ADC capture FSM states.
package rfsoc_config;

  localparam int config_reg_width = 16;
  localparam int gpio_w           = 16;

  // gpio_ctrl bit indices
  localparam int sdata                 = 0;
  localparam int adc_capture_count_clk = 8;
  localparam int adc_pre_delay_clk     = 9;
  localparam int adc_decim_clk         = 10;

  typedef enum logic [1:0] {
    IDLE,
    PRE_DELAY,
    CAPTURE,
    DONE
  } adc_cap_state_t;

endpackage

// File: rtl/shift_register.sv
// Serially loaded configuration register, MSB first.
// A bit shifts in on each clk edge where en is high.
module shift_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered ADC capture: waits a pre-delay, then forwards a programmed number of
// (optionally decimated) ADC beats to the capture FIFO, flagging done and overflow.
module adc_capture_ctrl
  import rfsoc_config::*;
#(
  parameter int CFG_W = config_reg_width
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [255:0]        s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [255:0]        m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  input  logic [gpio_w-1:0]   gpio_ctrl,
  input  logic                trigger_in,
  input  logic                select_in,
  output logic                capture_active,
  output logic                capture_done,
  output logic                overflow
);

  logic [CFG_W-1:0] count_cfg;
  logic [CFG_W-1:0] pre_delay_cfg;
  logic [CFG_W-1:0] decim_cfg;

  // Shifting is enabled only while the PS has this channel selected.
  shift_register #(.WIDTH(CFG_W)) u_count_reg (
    .clk (clk),
    .rst (rst),
    .en  (select_in & gpio_ctrl[adc_capture_count_clk]),
    .din (gpio_ctrl[sdata]),
    .q   (count_cfg)
  );

  shift_register #(.WIDTH(CFG_W)) u_pre_delay_reg (
    .clk (clk),
    .rst (rst),
    .en  (select_in & gpio_ctrl[adc_pre_delay_clk]),
    .din (gpio_ctrl[sdata]),
    .q   (pre_delay_cfg)
  );

  shift_register #(.WIDTH(CFG_W)) u_decim_reg (
    .clk (clk),
    .rst (rst),
    .en  (select_in & gpio_ctrl[adc_decim_clk]),
    .din (gpio_ctrl[sdata]),
    .q   (decim_cfg)
  );

  // The remaining bus bits belong to other channels.
  logic unused_gpio;
  assign unused_gpio = ^gpio_ctrl;

  assign s_axis_tready = 1'b1;

  adc_cap_state_t   state;
  logic [CFG_W-1:0] remaining;
  logic [CFG_W-1:0] delay_cnt;
  logic [CFG_W-1:0] decim_ld;
  logic [CFG_W-1:0] phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      remaining      <= '0;
      delay_cnt      <= '0;
      decim_ld       <= '0;
      phase          <= '0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      capture_active <= 1'b0;
      capture_done   <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;

      case (state)
        IDLE: begin
          if (trigger_in) begin
            remaining <= count_cfg;
            delay_cnt <= pre_delay_cfg;
            decim_ld  <= decim_cfg;
            phase     <= '0;
            overflow  <= 1'b0;
            if (count_cfg == '0) begin
              // Empty capture: pulse done immediately, never go active.
              state        <= DONE;
              capture_done <= 1'b1;
            end else begin
              capture_active <= 1'b1;
              state          <= (pre_delay_cfg != '0) ? PRE_DELAY : CAPTURE;
            end
          end
        end

        PRE_DELAY: begin
          delay_cnt <= delay_cnt - CFG_W'(1);
          if (delay_cnt == CFG_W'(1)) begin
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (s_axis_tvalid) begin
            if (phase == '0) begin
              phase     <= decim_ld;
              remaining <= remaining - CFG_W'(1);
              if (m_axis_tready) begin
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= (remaining == CFG_W'(1));
              end else begin
                // FIFO full: the beat is dropped but still consumes the count.
                overflow <= 1'b1;
              end
              if (remaining == CFG_W'(1)) begin
                state <= DONE;
              end
            end else begin
              phase <= phase - CFG_W'(1);
            end
          end
        end

        DONE: begin
          // Entered with done already high only from the empty-capture path.
          if (capture_done) begin
            capture_done <= 1'b0;
            state        <= IDLE;
          end else begin
            capture_done   <= 1'b1;
            capture_active <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: expected beats are queued when stimulus is
// driven and popped by a monitor when the DUT emits them; control outputs checked per cycle.
module tb_adc_capture_ctrl;
  import rfsoc_config::*;

  localparam int CFG_W = config_reg_width;

  logic               clk = 1'b0;
  logic               rst;
  logic [255:0]       s_axis_tdata;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic [255:0]       m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tlast;
  logic               m_axis_tready;
  logic [gpio_w-1:0]  gpio_ctrl;
  logic               trigger_in;
  logic               select_in;
  logic               capture_active;
  logic               capture_done;
  logic               overflow;

  adc_capture_ctrl #(.CFG_W(CFG_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .gpio_ctrl      (gpio_ctrl),
    .trigger_in     (trigger_in),
    .select_in      (select_in),
    .capture_active (capture_active),
    .capture_done   (capture_done),
    .overflow       (overflow)
  );

  always #2 clk = ~clk;

  // edge_cnt = number of rising edges so far; a beat registered at edge n is seen with edge_cnt == n.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [255:0] data;
    logic         last;
    int           edge_no;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   t0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] beat(input int n);
    logic [31:0] v;
    v = n;
    return {8{v}};
  endfunction

  // Advance one edge; data present at edge n is always beat(n).
  task automatic tick();
    @(posedge clk);
    #1;
    s_axis_tdata = beat(edge_cnt + 1);
  endtask

  task automatic push(input int edge_no, input logic last);
    exp_t e;
    e.data    = beat(edge_no);
    e.last    = last;
    e.edge_no = edge_no;
    exp_q.push_back(e);
  endtask

  task automatic load(input int strobe_idx, input logic [CFG_W-1:0] v);
    select_in = 1'b1;
    for (int i = CFG_W - 1; i >= 0; i--) begin
      gpio_ctrl             = '0;
      gpio_ctrl[strobe_idx] = 1'b1;
      gpio_ctrl[sdata]      = v[i];
      tick();
    end
    gpio_ctrl = '0;
    select_in = 1'b0;
  endtask

  task automatic trig(output int t);
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    t = edge_cnt;
  endtask

  // Run n edges after trigger t, checking done/active each cycle.
  task automatic run(input int t, input int n, input int done_at, input int act_last,
                     input bit alt, input int ready_low);
    for (int k = 0; k < n; k++) begin
      int nxt;
      nxt = edge_cnt + 1;
      s_axis_tvalid = alt ? ((nxt - t) % 2 == 1) : 1'b1;
      m_axis_tready = (nxt != ready_low);
      tick();
      check("capture_done", capture_done, edge_cnt == done_at);
      check("capture_active", capture_active, edge_cnt <= act_last);
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (m_axis_tlast) check("stray_tlast", m_axis_tvalid, 1);
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", edge_cnt, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", m_axis_tdata, mon_e.data);
          check("beat_last", m_axis_tlast, mon_e.last);
          check("beat_edge", edge_cnt, mon_e.edge_no);
        end
      end
    end
  end

  initial begin
    rst           = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    gpio_ctrl     = '0;
    trigger_in    = 1'b0;
    select_in     = 1'b0;
    tick();
    tick();
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_active", capture_active, 0);
    check("rst_done", capture_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tready", s_axis_tready, 1);
    rst = 1'b1;
    tick();

    // Basic capture: 4 beats, no delay, no decimation.
    load(adc_capture_count_clk, CFG_W'(4));
    trig(t0);
    check("t1_active_at_trig", capture_active, 1);
    for (int i = 1; i <= 4; i++) push(t0 + i, i == 4);
    run(t0, 6, t0 + 5, t0 + 4, 1'b0, -1);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_overflow", overflow, 0);

    // Pre-delay 3, count 2.
    load(adc_pre_delay_clk, CFG_W'(3));
    load(adc_capture_count_clk, CFG_W'(2));
    trig(t0);
    push(t0 + 4, 1'b0);
    push(t0 + 5, 1'b1);
    run(t0, 7, t0 + 6, t0 + 5, 1'b0, -1);
    check("t2_queue_empty", exp_q.size(), 0);

    // Decimation 2, count 3: slots 0, 3, 6 kept.
    load(adc_pre_delay_clk, CFG_W'(0));
    load(adc_decim_clk, CFG_W'(2));
    load(adc_capture_count_clk, CFG_W'(3));
    trig(t0);
    push(t0 + 1, 1'b0);
    push(t0 + 4, 1'b0);
    push(t0 + 7, 1'b1);
    run(t0, 9, t0 + 8, t0 + 7, 1'b0, -1);
    check("t3_queue_empty", exp_q.size(), 0);

    // Gappy input: only valid slots forwarded.
    load(adc_decim_clk, CFG_W'(0));
    trig(t0);
    push(t0 + 1, 1'b0);
    push(t0 + 3, 1'b0);
    push(t0 + 5, 1'b1);
    run(t0, 7, t0 + 6, t0 + 5, 1'b1, -1);
    check("t4_queue_empty", exp_q.size(), 0);

    // FIFO full on the 2nd of 4 beats: beat lost, overflow sticky, timing unchanged.
    load(adc_capture_count_clk, CFG_W'(4));
    trig(t0);
    push(t0 + 1, 1'b0);
    push(t0 + 3, 1'b0);
    push(t0 + 4, 1'b1);
    run(t0, 6, t0 + 5, t0 + 4, 1'b0, t0 + 2);
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_overflow_set", overflow, 1);
    tick();
    tick();
    check("t5_overflow_sticky", overflow, 1);

    // Empty capture: done at trigger edge, never active; trigger clears overflow.
    load(adc_capture_count_clk, CFG_W'(0));
    check("t6_overflow_before", overflow, 1);
    trig(t0);
    check("t6_overflow_cleared", overflow, 0);
    check("t6_done_now", capture_done, 1);
    check("t6_active", capture_active, 0);
    run(t0, 3, -1, t0 - 1, 1'b0, -1);

    // Reset mid-capture.
    load(adc_capture_count_clk, CFG_W'(8));
    trig(t0);
    push(t0 + 1, 1'b0);
    push(t0 + 2, 1'b0);
    run(t0, 3, -1, t0 + 20, 1'b0, -1);
    rst = 1'b0;
    #1;
    check("t7_rst_tdata", m_axis_tdata, 0);
    check("t7_rst_tvalid", m_axis_tvalid, 0);
    check("t7_rst_tlast", m_axis_tlast, 0);
    check("t7_rst_active", capture_active, 0);
    check("t7_rst_done", capture_done, 0);
    check("t7_queue_empty", exp_q.size(), 0);
    tick();
    rst = 1'b1;
    tick();
    // Config registers were reset, so this trigger is an empty capture.
    trig(t0);
    check("t7_cfg_reset_done", capture_done, 1);
    run(t0, 2, -1, t0 - 1, 1'b0, -1);
    load(adc_capture_count_clk, CFG_W'(2));
    trig(t0);
    push(t0 + 1, 1'b0);
    push(t0 + 2, 1'b1);
    run(t0, 4, t0 + 3, t0 + 2, 1'b0, -1);
    check("t7_post_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
